// File: rtl/tri_pkg.sv
// Shared definitions for the triangle fetch scheduler: state encoding,
// triangle stride and per-coordinate word indices within a triangle.
package tri_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    ISSUE = 3'd4,
    DONE  = 3'd5
  } tri_state_e;

  localparam int TRI_WORDS = 9;

  localparam int V0X = 0;
  localparam int V0Y = 1;
  localparam int V0Z = 2;
  localparam int V1X = 3;
  localparam int V1Y = 4;
  localparam int V1Z = 5;
  localparam int V2X = 6;
  localparam int V2Y = 7;
  localparam int V2Z = 8;

endpackage

// File: rtl/tri_degen_check.sv
// Combinational degenerate-triangle detector: flags a triangle when any two
// of its three vertices (xyz triplets) are bitwise identical.
module tri_degen_check
  import tri_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [TRI_WORDS*DATA_WIDTH-1:0] words,
  output logic                            degenerate
);

  logic [3*DATA_WIDTH-1:0] v0;
  logic [3*DATA_WIDTH-1:0] v1;
  logic [3*DATA_WIDTH-1:0] v2;

  assign v0 = words[V0X*DATA_WIDTH +: 3*DATA_WIDTH];
  assign v1 = words[V1X*DATA_WIDTH +: 3*DATA_WIDTH];
  assign v2 = words[V2X*DATA_WIDTH +: 3*DATA_WIDTH];

  assign degenerate = (v0 == v1) || (v0 == v2) || (v1 == v2);

endmodule

// File: rtl/tri_fetch_scheduler.sv
// Frame sequencer for the vertex-memory path: one-time preload, then fetches
// and issues each 9-word triangle. TRI_SCHED_SKIP_DEGENERATE_EN drops
// triangles with coincident vertices and exposes skip_count.
module tri_fetch_scheduler
  import tri_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TRI    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            go,
  output logic                            busy,
  output logic                            done,
  output logic                            load_start,
  input  logic                            load_finish,
  output logic [ADDR_WIDTH-1:0]           ram_read_addr,
  input  logic [TRI_WORDS*DATA_WIDTH-1:0] ram_rd_data,
  output logic                            tri_valid,
  input  logic                            tri_ready,
  output logic [TRI_WORDS*DATA_WIDTH-1:0] tri_data,
  output logic [ADDR_WIDTH-1:0]           tri_index
`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
  ,
  output logic [ADDR_WIDTH-1:0]           skip_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(TRI_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = (NUM_TRI > 0) ? ADDR_WIDTH'(NUM_TRI - 1) : '0;

  tri_state_e              state, state_nxt;
  logic                    loaded, loaded_nxt;
  logic [ADDR_WIDTH-1:0]   base, base_nxt;
  logic [ADDR_WIDTH-1:0]   idx_nxt;
  logic                    load_start_nxt;
  logic                    capture;
  logic                    last_tri;
  logic                    degen;

`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
  tri_degen_check #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_degen (
    .words      (ram_rd_data),
    .degenerate (degen)
  );
`else
  assign degen = 1'b0;
`endif

  assign last_tri = (tri_index == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      loaded     <= 1'b0;
      base       <= '0;
      tri_index  <= '0;
      tri_data   <= '0;
      load_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      loaded     <= loaded_nxt;
      base       <= base_nxt;
      tri_index  <= idx_nxt;
      load_start <= load_start_nxt;
      if (capture) tri_data <= ram_rd_data;
    end
  end

  always_comb begin
    state_nxt      = state;
    loaded_nxt     = loaded;
    base_nxt       = base;
    idx_nxt        = tri_index;
    load_start_nxt = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (loaded) begin
            state_nxt = FETCH;
            base_nxt  = '0;
            idx_nxt   = '0;
          end else begin
            state_nxt      = LOAD;
            load_start_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (load_finish) begin
          loaded_nxt = 1'b1;
          base_nxt   = '0;
          idx_nxt    = '0;
          state_nxt  = (NUM_TRI == 0) ? DONE : FETCH;
        end
      end
      FETCH: state_nxt = WAIT;
      WAIT: begin
        capture = 1'b1;
        // A degenerate triangle advances exactly like an accepted one.
        if (degen) begin
          if (last_tri) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FETCH;
            base_nxt  = base + STRIDE;
            idx_nxt   = tri_index + 1'b1;
          end
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (tri_ready) begin
          if (last_tri) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FETCH;
            base_nxt  = base + STRIDE;
            idx_nxt   = tri_index + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state == LOAD) || (state == FETCH) || (state == WAIT) || (state == ISSUE);
  assign done          = (state == DONE);
  assign tri_valid     = (state == ISSUE);
  assign ram_read_addr = ((state == FETCH) || (state == WAIT) || (state == ISSUE)) ? base : '0;

`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_count <= '0;
    end else if ((state == IDLE) && go) begin
      skip_count <= '0;
    end else if ((state == WAIT) && degen) begin
      skip_count <= skip_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tri_fetch_scheduler.sv
// Scoreboard bench for tri_fetch_scheduler: randomized RAM contents and
// rasterizer backpressure against a frame-level reference model.
module tb_tri_fetch_scheduler;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NT = 2;
  localparam int TW = 9 * DW;

  logic          clk;
  logic          reset;
  logic          go;
  logic          busy, done, load_start, load_finish;
  logic [AW-1:0] ram_read_addr;
  logic [TW-1:0] ram_rd_data;
  logic          tri_valid, tri_ready;
  logic [TW-1:0] tri_data;
  logic [AW-1:0] tri_index;

  logic          z_go;
  logic          z_busy, z_done, z_load_start;
  logic          z_load_finish;
  logic [AW-1:0] z_ram_read_addr;
  logic [TW-1:0] z_ram_rd_data;
  logic          z_tri_valid;
  logic          z_tri_ready;
  logic [TW-1:0] z_tri_data;
  logic [AW-1:0] z_tri_index;
`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
  logic [AW-1:0] skip_count;
  logic [AW-1:0] z_skip_count;
`endif

  tri_fetch_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TRI(NT)) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done),
    .load_start(load_start), .load_finish(load_finish),
    .ram_read_addr(ram_read_addr), .ram_rd_data(ram_rd_data),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_data(tri_data), .tri_index(tri_index)
`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
    , .skip_count(skip_count)
`endif
  );

  tri_fetch_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TRI(0)) dut_zero (
    .clk(clk), .reset(reset), .go(z_go), .busy(z_busy), .done(z_done),
    .load_start(z_load_start), .load_finish(z_load_finish),
    .ram_read_addr(z_ram_read_addr), .ram_rd_data(z_ram_rd_data),
    .tri_valid(z_tri_valid), .tri_ready(z_tri_ready),
    .tri_data(z_tri_data), .tri_index(z_tri_index)
`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
    , .skip_count(z_skip_count)
`endif
  );

  typedef struct {
    logic [AW-1:0] idx;
    logic [TW-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [DW-1:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          ls_cnt = 0;
  int          done_cnt = 0;
  int          exp_skip = 0;
  int          ready_mode = 0;
  bit          z_valid_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ram_rd_data = '0;
    for (int k = 0; k < 9; k++)
      ram_rd_data[k*DW +: DW] = mem[8'(ram_read_addr + 8'(k))];
  end

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] tri_words(input int i);
    logic [TW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = mem[(9 * i + k) % 256];
    return w;
  endfunction

  function automatic bit is_degen(input logic [TW-1:0] w);
    logic [3*DW-1:0] a, b, c;
    a = w[0 +: 3*DW];
    b = w[3*DW +: 3*DW];
    c = w[6*DW +: 3*DW];
    return (a == b) || (a == c) || (b == c);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic push_frame();
    exp_t e;
    exp_skip = 0;
    for (int i = 0; i < NT; i++) begin
      e.idx  = AW'(i);
      e.data = tri_words(i);
`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
      if (is_degen(e.data)) begin
        exp_skip++;
        continue;
      end
`endif
      exp_q.push_back(e);
    end
  endtask

  // Preload model: finish rises 19 cycles after load_start and stays high.
  initial begin
    int cnt;
    cnt = 0;
    load_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        load_finish = 1'b0;
        cnt = 0;
      end else if (load_start) begin
        load_finish = 1'b0;
        cnt = 19;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) load_finish = 1'b1;
      end
    end
  end

  initial begin
    tri_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       tri_ready = 1'b0;
        2:       tri_ready = 1'b1;
        default: tri_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted triangle and checks
  // hold-stability, no back-to-back issue and the next fetch address.
  initial begin
    logic          p_valid, p_ready, p_acc;
    logic [TW-1:0] p_data;
    logic [AW-1:0] p_idx;
    exp_t          e;
    p_valid = 0; p_ready = 0; p_acc = 0; p_data = '0; p_idx = '0;
    forever begin
      @(negedge clk);
      if (z_tri_valid) z_valid_seen = 1;
      if (!reset) begin
        p_valid = 0; p_ready = 0; p_acc = 0;
        continue;
      end
      if (load_start) ls_cnt++;
      if (done) done_cnt++;
      if (p_acc) begin
        check("no_back_to_back", tri_valid, 0);
        if (int'(p_idx) < NT - 1)
          check("next_fetch_addr", ram_read_addr, 9 * (int'(p_idx) + 1));
      end
      if (tri_valid && p_valid && !p_ready) begin
        check("hold_data", tri_data, p_data);
        check("hold_index", tri_index, p_idx);
      end
      if (tri_valid && tri_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_triangle", tri_index, {AW{1'bx}});
        end else begin
          e = exp_q.pop_front();
          check("tri_data", tri_data, e.data);
          check("tri_index", tri_index, e.idx);
        end
      end
      p_acc   = tri_valid && tri_ready;
      p_valid = tri_valid;
      p_ready = tri_ready;
      p_data  = tri_data;
      p_idx   = tri_index;
    end
  end

  task automatic do_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_valid_idx(input logic [AW-1:0] idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tri_valid && tri_index == idx) return;
    end
    check("valid_timeout", tri_index, idx);
  endtask

  task automatic post_frame(input int ls_exp, input int done_exp);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    check("valid_after", tri_valid, 0);
    check("addr_after", ram_read_addr, 0);
    check("queue_drained", exp_q.size(), 0);
    check("load_start_count", ls_cnt, ls_exp);
    check("done_count", done_cnt, done_exp);
`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
    check("skip_count", skip_count, exp_skip);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_load_start"}, load_start, 0);
    check({tag, "_valid"}, tri_valid, 0);
    check({tag, "_addr"}, ram_read_addr, 0);
    check({tag, "_data"}, tri_data, 0);
    check({tag, "_index"}, tri_index, 0);
  endtask

  initial begin
    int ls0, d0;
    reset = 1'b0;
    go = 1'b0;
    z_go = 1'b0;
    z_load_finish = 1'b1;
    z_ram_rd_data = '0;
    z_tri_ready = 1'b1;
    fill_mem();
    #2;
    check_reset_outputs("reset");
    check("z_reset_busy", z_busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Frame 1: preload then two triangles.
    push_frame();
    ls0 = ls_cnt; d0 = done_cnt;
    do_go();
    check("load_start_pulse", load_start, 1);
    check("busy_in_load", busy, 1);
    wait_done(400);
    post_frame(ls0 + 1, d0 + 1);

    // Frame 2: already loaded, 2-cycle go-to-valid latency.
    fill_mem();
    push_frame();
    ls0 = ls_cnt; d0 = done_cnt;
    do_go();
    check("fetch_addr0", ram_read_addr, 0);
    check("lat_fetch_valid", tri_valid, 0);
    @(posedge clk); #1;
    check("lat_wait_valid", tri_valid, 0);
    @(posedge clk); #1;
    check("lat_issue_valid", tri_valid, 1);
    wait_done(400);
    post_frame(ls0, d0 + 1);

    // Frame 3: rasterizer stalls 10 cycles on triangle 0.
    fill_mem();
    push_frame();
    ready_mode = 1;
    ls0 = ls_cnt; d0 = done_cnt;
    do_go();
    wait_valid_idx(0, 20);
    repeat (10) @(posedge clk);
    #1;
    check("stall_valid_held", tri_valid, 1);
    check("stall_index_held", tri_index, 0);
    ready_mode = 2;
    wait_done(100);
    post_frame(ls0, d0 + 1);
    ready_mode = 0;

    // Reset during ISSUE of triangle 1, then a go must reload.
    fill_mem();
    push_frame();
    do_go();
    wait_valid_idx(1, 400);
    ready_mode = 1;
    #3 reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ready_mode = 0;
    push_frame();
    ls0 = ls_cnt; d0 = done_cnt;
    do_go();
    check("reload_start", load_start, 1);
    wait_done(400);
    post_frame(ls0 + 1, d0 + 1);

    // NUM_TRI=0 instance with load_finish already high.
    @(negedge clk);
    z_go = 1'b1;
    @(posedge clk);
    #1 z_go = 1'b0;
    check("z_load_start", z_load_start, 1);
    check("z_busy_load", z_busy, 1);
    @(posedge clk); #1;
    check("z_done", z_done, 1);
    check("z_busy_done", z_busy, 0);
    @(posedge clk); #1;
    check("z_done_cleared", z_done, 0);
    check("z_never_valid", z_valid_seen, 0);

    // Random frames with random backpressure.
    for (int f = 0; f < 4; f++) begin
      fill_mem();
      push_frame();
      ls0 = ls_cnt; d0 = done_cnt;
      do_go();
      wait_done(400);
      post_frame(ls0, d0 + 1);
    end

`ifdef TRI_SCHED_SKIP_DEGENERATE_EN
    fill_mem();
    for (int k = 0; k < 3; k++) mem[6 + k] = mem[k];
    push_frame();
    check("model_skip_one", exp_skip, 1);
    ls0 = ls_cnt; d0 = done_cnt;
    do_go();
    wait_done(400);
    post_frame(ls0, d0 + 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
